// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: ALU op codes, mux selects,
// MIPS opcode/funct constants, FSM state and decoded instruction class.
package mc_ctrl_pkg;

  // ALU operation codes driven on ALUOp
  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  // next-PC select
  localparam logic [1:0] NPC_PLUS4  = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  // register write-data select
  localparam logic [1:0] WDSEL_ALU = 2'd0;
  localparam logic [1:0] WDSEL_MEM = 2'd1;
  localparam logic [1:0] WDSEL_PC  = 2'd2;

  // destination register select
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  // ALU operand selects
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS    = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;
  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;

  // opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [2:0] {
    S_FETCH, S_DCODE, S_EXE, S_MEM, S_WB_ALU, S_WB_MEM, S_BRANCH
  } state_t;

  // instruction classes that steer the sequence and per-state selects
  typedef enum logic [3:0] {
    C_ILLEGAL,   // unsupported encoding, executes as NOP
    C_RALU,      // R-type ALU op with rs/rt operands (incl. sllv/srlv)
    C_SHIFT_SA,  // sll/srl using the shamt field as operand A
    C_IMM_SEXT,  // addi/slti
    C_IMM_ZEXT,  // andi/ori/lui
    C_LW,
    C_SW,
    C_BEQ,
    C_BNE,
    C_J,
    C_JAL,
    C_JR
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: Op/Funct -> instruction class, the ALU
// operation used in EXE, and an illegal flag. Shift and lui support is only
// decoded when MC_CTRL_SHIFT_EN is defined; otherwise they are illegal.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic [3:0] exe_aluop,
  output logic       illegal
);

  // classify the instruction and pick its execute-stage ALU operation
  always_comb begin
    iclass    = C_ILLEGAL;
    exe_aluop = ALU_NOP;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin iclass = C_RALU; exe_aluop = ALU_ADD;  end
          FN_SUB:  begin iclass = C_RALU; exe_aluop = ALU_SUB;  end
          FN_AND:  begin iclass = C_RALU; exe_aluop = ALU_AND;  end
          FN_OR:   begin iclass = C_RALU; exe_aluop = ALU_OR;   end
          FN_SLT:  begin iclass = C_RALU; exe_aluop = ALU_SLT;  end
          FN_SLTU: begin iclass = C_RALU; exe_aluop = ALU_SLTU; end
          FN_NOR:  begin iclass = C_RALU; exe_aluop = ALU_NOR;  end
          FN_JR:   iclass = C_JR;
`ifdef MC_CTRL_SHIFT_EN
          FN_SLL:  begin iclass = C_SHIFT_SA; exe_aluop = ALU_SLL; end
          FN_SRL:  begin iclass = C_SHIFT_SA; exe_aluop = ALU_SRL; end
          FN_SLLV: begin iclass = C_RALU;     exe_aluop = ALU_SLL; end
          FN_SRLV: begin iclass = C_RALU;     exe_aluop = ALU_SRL; end
`endif
          default: iclass = C_ILLEGAL;
        endcase
      end
      OP_J:    iclass = C_J;
      OP_JAL:  iclass = C_JAL;
      OP_BEQ:  iclass = C_BEQ;
      OP_BNE:  iclass = C_BNE;
      OP_ADDI: begin iclass = C_IMM_SEXT; exe_aluop = ALU_ADD; end
      OP_SLTI: begin iclass = C_IMM_SEXT; exe_aluop = ALU_SLT; end
      OP_ANDI: begin iclass = C_IMM_ZEXT; exe_aluop = ALU_AND; end
      OP_ORI:  begin iclass = C_IMM_ZEXT; exe_aluop = ALU_OR;  end
`ifdef MC_CTRL_SHIFT_EN
      OP_LUI:  begin iclass = C_IMM_ZEXT; exe_aluop = ALU_LUI; end
`endif
      OP_LW:   begin iclass = C_LW; exe_aluop = ALU_ADD; end
      OP_SW:   begin iclass = C_SW; exe_aluop = ALU_ADD; end
      default: iclass = C_ILLEGAL;
    endcase
    illegal = (iclass == C_ILLEGAL);
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main control FSM. Sequences FETCH/DCODE/EXE/MEM/WB/BRANCH and
// drives Moore-style strobes and selects from state plus decoded Op/Funct.
// Optional macro MC_CTRL_SHIFT_EN enables sll/srl/sllv/srlv/lui decoding.
// While rst is high every output is held at zero (ALUOp = ALU_NOP).
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       EXTOp,
  output logic [3:0] ALUOp,
  output logic [1:0] NPCOp,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state_reg, state_next;
  iclass_t    iclass;
  logic [3:0] exe_aluop;
  logic       dec_illegal;

  mc_decode u_decode (
    .op        (Op),
    .funct     (Funct),
    .iclass    (iclass),
    .exe_aluop (exe_aluop),
    .illegal   (dec_illegal)
  );

  // state register; reset abandons any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  // next-state selection
  always_comb begin
    state_next = S_FETCH;
    unique case (state_reg)
      S_FETCH: state_next = S_DCODE;
      S_DCODE: begin
        case (iclass)
          C_J, C_JAL, C_JR, C_ILLEGAL: state_next = S_FETCH;
          C_BEQ, C_BNE:                state_next = S_BRANCH;
          default:                     state_next = S_EXE;
        endcase
      end
      S_EXE:    state_next = (iclass == C_LW || iclass == C_SW) ? S_MEM : S_WB_ALU;
      S_MEM:    state_next = (iclass == C_LW) ? S_WB_MEM : S_FETCH;
      S_WB_ALU: state_next = S_FETCH;
      S_WB_MEM: state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  // per-state strobes and selects; everything forced idle while rst is high
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = REGDST_RT;
    WDSel      = WDSEL_ALU;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RT;
    EXTOp      = 1'b0;
    ALUOp      = ALU_NOP;
    NPCOp      = NPC_PLUS4;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      unique case (state_reg)
        S_FETCH: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = SRCB_FOUR;
          ALUOp   = ALU_ADD;
        end
        S_DCODE: begin
          case (iclass)
            C_J: begin
              PCWrite = 1'b1; NPCOp = NPC_JUMP; instr_done = 1'b1;
            end
            C_JAL: begin
              PCWrite = 1'b1; NPCOp = NPC_JUMP; instr_done = 1'b1;
              RegWrite = 1'b1; RegDst = REGDST_RA; WDSel = WDSEL_PC;
            end
            C_JR: begin
              PCWrite = 1'b1; NPCOp = NPC_JR; instr_done = 1'b1;
            end
            C_ILLEGAL: begin
              illegal = dec_illegal; instr_done = 1'b1;
            end
            default: ;
          endcase
        end
        S_EXE: begin
          ALUSrcA = (iclass == C_SHIFT_SA) ? SRCA_SHAMT : SRCA_RS;
          ALUSrcB = (iclass == C_RALU || iclass == C_SHIFT_SA) ? SRCB_RT : SRCB_IMM;
          EXTOp   = (iclass == C_IMM_SEXT || iclass == C_LW || iclass == C_SW);
          ALUOp   = exe_aluop;
        end
        S_MEM: begin
          IorD = 1'b1;
          if (iclass == C_SW) begin
            MemWrite = 1'b1; instr_done = 1'b1;
          end
        end
        S_WB_ALU: begin
          RegWrite = 1'b1;
          RegDst   = (iclass == C_RALU || iclass == C_SHIFT_SA) ? REGDST_RD : REGDST_RT;
          instr_done = 1'b1;
        end
        S_WB_MEM: begin
          RegWrite = 1'b1; WDSel = WDSEL_MEM; instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA = SRCA_RS;
          ALUSrcB = SRCB_RT;
          ALUOp   = ALU_SUB;
          EXTOp   = 1'b1;
          NPCOp   = NPC_BRANCH;
          PCWrite = (iclass == C_BNE) ? ~Zero : Zero;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: each issued instruction pushes its expected
// cycle-by-cycle control vector timeline; a negedge monitor pops and compares.
// Honours MC_CTRL_SHIFT_EN the same way the design does.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       PCWrite, IRWrite, IorD, MemWrite, RegWrite, EXTOp, instr_done, illegal;
  logic [1:0] RegDst, WDSel, ALUSrcA, ALUSrcB, NPCOp;
  logic [3:0] ALUOp;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .WDSel(WDSel), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, irw, iord, memw, regw;
    logic [1:0] regdst, wdsel, srca, srcb;
    logic       ext;
    logic [3:0] alu;
    logic [1:0] npc;
    logic       done, ill;
  } ov_t;

  // instruction kinds as seen by the reference timeline
  localparam logic [3:0] K_J = 0, K_JAL = 1, K_JR = 2, K_ILL = 3, K_BEQ = 4, K_BNE = 5,
                         K_RALU = 6, K_SHAMT = 7, K_IMM = 8, K_LW = 9, K_SW = 10;

  typedef struct packed {
    logic [5:0] op, funct;
    logic [3:0] kind, alu;
    logic       ext;
  } instr_t;

  instr_t tbl[$];
  string  names[$];
  ov_t    exp_q[$];
  string  tag_q[$];
  int     checks = 0;
  int     errors = 0;
  int     seqno  = 0;

  function automatic ov_t dut_out();
    ov_t o;
    o.pcw = PCWrite; o.irw = IRWrite; o.iord = IorD; o.memw = MemWrite; o.regw = RegWrite;
    o.regdst = RegDst; o.wdsel = WDSel; o.srca = ALUSrcA; o.srcb = ALUSrcB; o.ext = EXTOp;
    o.alu = ALUOp; o.npc = NPCOp; o.done = instr_done; o.ill = illegal;
    return o;
  endfunction

  function automatic void add(string n, logic [5:0] op, logic [5:0] fn, logic [3:0] k,
                              logic [3:0] a, logic e);
    instr_t t;
    t.op = op; t.funct = fn; t.kind = k; t.alu = a; t.ext = e;
    tbl.push_back(t);
    names.push_back(n);
  endfunction

  function automatic int find(string n);
    for (int i = 0; i < names.size(); i++) if (names[i] == n) return i;
    return 0;
  endfunction

  function automatic void expect_cycle(ov_t v, string tag);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endfunction

  // reference timeline for one instruction, built from the per-instruction rules
  function automatic int model(instr_t t, logic z, string tag);
    ov_t blank = '0;
    ov_t v;
    int  n = exp_q.size();
    v = blank; v.irw = 1; v.pcw = 1; v.srcb = SRCB_FOUR; v.alu = ALU_ADD;
    expect_cycle(v, {tag, ":fetch"});
    case (t.kind)
      K_J, K_JAL, K_JR: begin
        v = blank; v.pcw = 1; v.done = 1;
        v.npc = (t.kind == K_JR) ? NPC_JR : NPC_JUMP;
        if (t.kind == K_JAL) begin v.regw = 1; v.regdst = REGDST_RA; v.wdsel = WDSEL_PC; end
        expect_cycle(v, {tag, ":dcode"});
      end
      K_ILL: begin
        v = blank; v.ill = 1; v.done = 1;
        expect_cycle(v, {tag, ":dcode"});
      end
      K_BEQ, K_BNE: begin
        expect_cycle(blank, {tag, ":dcode"});
        v = blank; v.srca = SRCA_RS; v.srcb = SRCB_RT; v.alu = ALU_SUB; v.ext = 1;
        v.npc = NPC_BRANCH; v.done = 1;
        v.pcw = (t.kind == K_BEQ) ? z : !z;
        expect_cycle(v, {tag, ":branch"});
      end
      K_RALU, K_SHAMT, K_IMM: begin
        expect_cycle(blank, {tag, ":dcode"});
        v = blank; v.alu = t.alu; v.ext = t.ext;
        v.srca = (t.kind == K_SHAMT) ? SRCA_SHAMT : SRCA_RS;
        v.srcb = (t.kind == K_IMM) ? SRCB_IMM : SRCB_RT;
        expect_cycle(v, {tag, ":exe"});
        v = blank; v.regw = 1; v.done = 1;
        v.regdst = (t.kind == K_IMM) ? REGDST_RT : REGDST_RD;
        expect_cycle(v, {tag, ":wb"});
      end
      default: begin  // K_LW / K_SW
        expect_cycle(blank, {tag, ":dcode"});
        v = blank; v.srca = SRCA_RS; v.srcb = SRCB_IMM; v.ext = 1; v.alu = ALU_ADD;
        expect_cycle(v, {tag, ":exe"});
        v = blank; v.iord = 1;
        if (t.kind == K_SW) begin v.memw = 1; v.done = 1; end
        expect_cycle(v, {tag, ":mem"});
        if (t.kind == K_LW) begin
          v = blank; v.regw = 1; v.wdsel = WDSEL_MEM; v.done = 1;
          expect_cycle(v, {tag, ":wbmem"});
        end
      end
    endcase
    return exp_q.size() - n;
  endfunction

  // called at #1 after a posedge with the DUT in FETCH
  task automatic issue(int idx, logic z);
    instr_t t = tbl[idx];
    logic [5:0] fn;
    int n;
    string tag;
    fn  = (t.op == OP_RTYPE) ? t.funct : 6'($urandom_range(0, 63));
    tag = $sformatf("%s#%0d", names[idx], seqno);
    seqno++;
    n = model(t, z, tag);
    Op = t.op; Funct = fn; Zero = z;
    $display("instr %-8s op=%h funct=%h zero=%b cycles=%0d", tag, t.op, fn, z, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor: compare every presented cycle against the scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ov_t e, a;
      string tg;
      e = exp_q.pop_front();
      tg = tag_q.pop_front();
      a = dut_out();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s got=%h want=%h (pcw irw iord memw regw rd wd sa sb ext alu npc done ill)",
                 tg, a, e);
      end
    end
  end

  task automatic check_idle(string tg);
    ov_t a = dut_out();
    checks++;
    if (a !== ov_t'(0)) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tg, a, ov_t'(0));
    end
  endtask

  initial begin
    ov_t f;
    add("add", OP_RTYPE, FN_ADD, K_RALU, ALU_ADD, 0);
    add("sub", OP_RTYPE, FN_SUB, K_RALU, ALU_SUB, 0);
    add("and", OP_RTYPE, FN_AND, K_RALU, ALU_AND, 0);
    add("or",  OP_RTYPE, FN_OR,  K_RALU, ALU_OR,  0);
    add("slt", OP_RTYPE, FN_SLT, K_RALU, ALU_SLT, 0);
    add("sltu", OP_RTYPE, FN_SLTU, K_RALU, ALU_SLTU, 0);
    add("nor", OP_RTYPE, FN_NOR, K_RALU, ALU_NOR, 0);
    add("jr",  OP_RTYPE, FN_JR,  K_JR,  ALU_NOP, 0);
`ifdef MC_CTRL_SHIFT_EN
    add("sll",  OP_RTYPE, FN_SLL,  K_SHAMT, ALU_SLL, 0);
    add("srl",  OP_RTYPE, FN_SRL,  K_SHAMT, ALU_SRL, 0);
    add("sllv", OP_RTYPE, FN_SLLV, K_RALU,  ALU_SLL, 0);
    add("srlv", OP_RTYPE, FN_SRLV, K_RALU,  ALU_SRL, 0);
    add("lui",  OP_LUI,   6'h00,   K_IMM,   ALU_LUI, 0);
`else
    add("sll",  OP_RTYPE, FN_SLL,  K_ILL, ALU_NOP, 0);
    add("srl",  OP_RTYPE, FN_SRL,  K_ILL, ALU_NOP, 0);
    add("sllv", OP_RTYPE, FN_SLLV, K_ILL, ALU_NOP, 0);
    add("srlv", OP_RTYPE, FN_SRLV, K_ILL, ALU_NOP, 0);
    add("lui",  OP_LUI,   6'h00,   K_ILL, ALU_NOP, 0);
`endif
    add("addi", OP_ADDI, 6'h00, K_IMM, ALU_ADD, 1);
    add("slti", OP_SLTI, 6'h00, K_IMM, ALU_SLT, 1);
    add("andi", OP_ANDI, 6'h00, K_IMM, ALU_AND, 0);
    add("ori",  OP_ORI,  6'h00, K_IMM, ALU_OR,  0);
    add("lw",   OP_LW,   6'h00, K_LW,  ALU_ADD, 1);
    add("sw",   OP_SW,   6'h00, K_SW,  ALU_ADD, 1);
    add("beq",  OP_BEQ,  6'h00, K_BEQ, ALU_SUB, 1);
    add("bne",  OP_BNE,  6'h00, K_BNE, ALU_SUB, 1);
    add("j",    OP_J,    6'h00, K_J,   ALU_NOP, 0);
    add("jal",  OP_JAL,  6'h00, K_JAL, ALU_NOP, 0);
    add("ill3f", 6'h3F, 6'h00, K_ILL, ALU_NOP, 0);
    add("ill01", 6'h01, 6'h00, K_ILL, ALU_NOP, 0);
    add("ill06", 6'h06, 6'h00, K_ILL, ALU_NOP, 0);
    add("ill20", 6'h20, 6'h00, K_ILL, ALU_NOP, 0);
    add("illf21", OP_RTYPE, 6'h21, K_ILL, ALU_NOP, 0);
    add("illf03", OP_RTYPE, 6'h03, K_ILL, ALU_NOP, 0);
    add("illf3f", OP_RTYPE, 6'h3F, K_ILL, ALU_NOP, 0);

    // power-up reset: everything idle
    rst = 1'b1; Op = OP_RTYPE; Funct = FN_ADD; Zero = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_idle("reset_idle");
    rst = 1'b0;
    issue(find("add"), 1'b0);

    // reset in the middle of an add's EXE cycle
    f = '0;
    void'(model(tbl[find("add")], 1'b0, "add_rst"));
    void'(exp_q.pop_back());  // the EXE and WB cycles never happen
    void'(tag_q.pop_back());
    void'(exp_q.pop_back());
    void'(tag_q.pop_back());
    Op = OP_RTYPE; Funct = FN_ADD;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_idle("rst_mid_exe");
    @(posedge clk);
    #1 check_idle("rst_held");
    rst = 1'b0;

    // directed boundary cases (first one also proves FETCH right after release)
    issue(find("lw"), 1'b0);
    issue(find("beq"), 1'b1);
    issue(find("beq"), 1'b0);
    issue(find("bne"), 1'b1);
    issue(find("bne"), 1'b0);
    issue(find("jal"), 1'b0);
    issue(find("sll"), 1'b0);
    issue(find("ill3f"), 1'b1);
    issue(find("sw"), 1'b0);
    issue(find("lui"), 1'b0);

    // randomized instruction stream
    for (int i = 0; i < 300; i++)
      issue($urandom_range(0, tbl.size() - 1), 1'($urandom_range(0, 1)));

    // every expected cycle must have been consumed by the monitor
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
